fp80_to_fp64_conv: RTL and testbench
====================================

FP80_TO_FP64_CONV -- requirements
Module: fp80_to_fp64_conv

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock.
REQ-002 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit, which marks the input operand as valid.
REQ-004 SHALL have port in_ready, output, 1 bit, which signals that the converter accepts an operand.
REQ-005 SHALL have port in_data, input, 80 bits, the x87 extended operand {sign, exp[14:0], mant[63:0] with explicit J bit}.
REQ-006 SHALL have port out_valid, output, 1 bit, which marks the result as valid.
REQ-007 SHALL have port out_ready, input, 1 bit, which signals that the consumer (binary64 adder operand register) accepts the result.
REQ-008 SHALL have port out_data, output, 64 bits, the binary64 result.
REQ-009 SHALL have ports out_inexact, out_overflow, out_underflow and out_invalid, outputs, 1 bit each, the flags of the current result.

Function
REQ-010 SHALL implement FSM states IDLE, NORM, ROUND and DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE; an operand is accepted on in_valid&in_ready; there is no overlap of operands.
REQ-012 SHALL, on acceptance, register sign, exp (17-bit signed working width) and mant, then go to NORM if exp!=0, J=0 and mant!=0 (unnormal), otherwise go to ROUND.
REQ-013 SHALL, in each NORM cycle: if mant[63:56]==0, shift mant left 8, subtract 8 from exp and stay in NORM; otherwise shift left by lzc(mant[63:56]) (0..7), subtract the same amount and go to ROUND. The number of NORM cycles is floor(lz/8)+1.
REQ-014 SHALL classify in ROUND and register the result into out_* on entry to DONE:
- zero (exp=0, mant=0): {s,63'b0}, no flags.
- exp=0 with mant!=0 (denormal/pseudo-denormal): {s,63'b0}, underflow=1, inexact=1.
- exp=7FFF with mant[62:0]=0: {s,7FF,0}, no flags.
- exp=7FFF with mant[62:0]!=0: {s,7FF,1,51'b0}; invalid=1 if mant[62]=0 (SNaN).
- Otherwise: e64 = exp-15360.
REQ-015 SHALL round the normal path to nearest, ties to even, using frac=mant[62:11], g=mant[10], r=mant[9], sticky=|mant[8:0], inc=g&(r|sticky|frac[0]); a carry out of frac SHALL increment e64 and zero frac.
REQ-016 SHALL, when the post-round e64>=2047, output {s,7FF,0} with overflow=1 and inexact=1.
REQ-017 SHALL, when e64<=0, output {s,63'b0} with underflow=1 and inexact=1; fp64 subnormals are flushed, never produced.
REQ-018 SHALL set inexact=g|r|sticky for in-range normal results.
REQ-019 SHALL produce out_valid exactly 2 cycles after acceptance when NORM is skipped, and 2+NORM cycles otherwise.
REQ-020 SHALL hold out_valid=1 and keep out_data and flags stable until out_ready; on the handshake it goes to IDLE, with in_ready=1 in the next cycle.

Reset
REQ-021 SHALL, on rst asserted (any state, including mid-NORM), force IDLE, out_valid=0, out_data=0, all flags=0, in_ready=1 from the first clock-independent moment; the operand in flight is discarded.

Configuration
REQ-022 SHALL, with FP80_CONV_UNNORM_EN defined, implement NORM per REQ-013.
REQ-023 SHALL, without FP80_CONV_UNNORM_EN, omit NORM; unnormals then produce {s,63'b0} with underflow=0, inexact=1, and latency is fixed at 2.

Structure
REQ-024 SHALL take the following from shared package fp_pkg: FP80_BIAS=16383, FP64_BIAS=1023, FP_REBIAS=15360, FP64_QNAN=64'h7FF8_0000_0000_0000, FP64_EXP_MAX=2047, and the FSM state typedef.
REQ-025 SHALL instantiate one sub-module, fp_lzc8 (8-bit leading-zero count, 3-bit result), used in NORM.

Verification
REQ-026 Normal and latency: in 0x3FFF_8000000000000000 -> out 0x3FF0000000000000, flags 0, out_valid 2 cycles after accept.
REQ-027 Rounding, exp 0x3FFF:
- mant 0x8000000000000400 (tie, even) -> 0x3FF0000000000000, inexact=1.
- mant 0x8000000000000C00 (tie, odd) -> 0x3FF0000000000002, inexact=1.
REQ-028 Overflow and underflow:
- 0x43FF_8000000000000000 -> 0x7FF0000000000000, overflow=1, inexact=1.
- 0xBC00_8000000000000000 -> 0x8000000000000000, underflow=1, inexact=1.
REQ-029 Unnormal: 0x4013_0000080000000000 -> 0x3FF0000000000000, 3 NORM cycles, latency 5; without the macro -> 0x0000000000000000, inexact=1.
REQ-030 Backpressure and NaN: SNaN 0x7FFF_A000000000000000 with out_ready low for 4 cycles -> out_data 0x7FF8000000000000 stable, invalid=1, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-031 Reset: rst pulse during the 2nd NORM cycle -> out_valid=0, in_ready=1 immediately; the next operand converts normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the x87 extended to binary64
// converter.
//   FP80_BIAS / FP64_BIAS  : exponent biases of the two formats
//   FP_REBIAS              : difference of the biases (fp80 exp -> fp64 exp)
//   FP64_QNAN              : default quiet NaN pattern
//   FP64_EXP_MAX           : all-ones binary64 exponent
//   conv_state_t           : converter FSM state
//   fp_flags_t             : exception flags carried with a result
package fp_pkg;

   localparam int FP80_BIAS    = 16383;
   localparam int FP64_BIAS    = 1023;
   localparam int FP_REBIAS    = FP80_BIAS - FP64_BIAS;   // 15360
   localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
   localparam int FP64_EXP_MAX = 2047;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } conv_state_t;

   typedef struct packed {
      logic inexact;
      logic overflow;
      logic underflow;
      logic invalid;
   } fp_flags_t;

endpackage

// File: rtl/fp80_to_fp64_conv_if.sv
// Handshake bundle of the fp80 -> fp64 converter.
//   in_valid/in_ready/in_data   : operand channel (80-bit x87 extended)
//   out_valid/out_ready/out_data: result channel (64-bit binary64)
//   out_inexact/overflow/underflow/invalid: flags travelling with out_data
// Modports: master = operand producer / result consumer, slave = converter.
interface fp80_to_fp64_conv_if;

   logic        in_valid;
   logic        in_ready;
   logic [79:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_inexact;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_invalid;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data,
             out_inexact, out_overflow, out_underflow, out_invalid
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data,
             out_inexact, out_overflow, out_underflow, out_invalid
   );

endinterface

// File: rtl/fp_lzc8.sv
// 8-bit leading-zero counter.
//   din : value to scan (bit 7 is the MSB)
//   cnt : number of leading zeros, 0..7; an all-zero input returns 7 and the
//         caller is expected to handle that case separately.
module fp_lzc8 (
   input  logic [7:0] din,
   output logic [2:0] cnt
);

   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      cnt = 3'd7;
      for (int i = 0; i < 8; i++) begin
         if (din[i]) cnt = 3'(7 - i);
      end
   end

endmodule

// File: rtl/fp80_to_fp64_conv.sv
// x87 80-bit extended -> IEEE binary64 converter, one operand in flight.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fp80_to_fp64_conv_if.slave (operand in, result + flags out)
// FSM: IDLE (accept) -> [NORM]* -> ROUND -> DONE (hold until out_ready).
// Rounding is nearest-even; binary64 subnormals are flushed to signed zero.
// Build option FP80_CONV_UNNORM_EN: when defined, unnormal operands are
// normalised in NORM (8 bits per cycle); otherwise they flush to signed zero
// with only inexact set and latency stays fixed at 2.
module fp80_to_fp64_conv
   import fp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   fp80_to_fp64_conv_if.slave   bus
);

   localparam logic signed [16:0] E_REBIAS = 17'(FP_REBIAS);
   localparam logic signed [16:0] E_MAX    = 17'(FP64_EXP_MAX);

   conv_state_t        state, state_nx;
   logic               sign_q;
   logic signed [16:0] exp_q;
   logic [63:0]        mant_q;
   logic [63:0]        out_q;
   fp_flags_t          flags_q;

   logic               accept;
   logic [63:0]        res_data;
   fp_flags_t          res_flags;

   assign accept = bus.in_valid && (state == IDLE);

`ifdef FP80_CONV_UNNORM_EN
   logic       in_unnorm;
   logic [2:0] lz;

   // Non-zero exponent, J clear, non-zero mantissa.
   assign in_unnorm = (bus.in_data[78:64] != 15'd0) && !bus.in_data[63] &&
                      (bus.in_data[63:0] != 64'd0);

   fp_lzc8 u_lzc (
      .din (mant_q[63:56]),
      .cnt (lz)
   );
`endif

   //---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef FP80_CONV_UNNORM_EN
               state_nx = in_unnorm ? NORM : ROUND;
`else
               state_nx = ROUND;
`endif
            end
         end
         NORM: begin
`ifdef FP80_CONV_UNNORM_EN
            if (mant_q[63:56] != 8'd0) state_nx = ROUND;
`else
            state_nx = ROUND;
`endif
         end
         ROUND:   state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   //---------------------------------------------------------- round/classify
   logic [51:0]        frac;
   logic               g, r, st, inc;
   logic [52:0]        frac_sum;
   logic signed [16:0] e64, e64_r;

   assign frac     = mant_q[62:11];
   assign g        = mant_q[10];
   assign r        = mant_q[9];
   assign st       = |mant_q[8:0];
   assign inc      = g & (r | st | frac[0]);
   assign frac_sum = {1'b0, frac} + {52'd0, inc};
   assign e64      = exp_q - E_REBIAS;
   // A carry out of the fraction leaves frac_sum[51:0] at zero already.
   assign e64_r    = frac_sum[52] ? e64 + 17'sd1 : e64;

   always_comb begin
      res_data  = {sign_q, 63'd0};
      res_flags = '0;
`ifndef FP80_CONV_UNNORM_EN
      if ((exp_q != 17'sd0) && !mant_q[63] && (mant_q != 64'd0)) begin
         res_flags.inexact = 1'b1;
      end else
`endif
      if (exp_q == 17'sd0) begin
         if (mant_q != 64'd0) begin
            res_flags.underflow = 1'b1;
            res_flags.inexact   = 1'b1;
         end
      end else if (exp_q == 17'sh7FFF) begin
         if (mant_q[62:0] == 63'd0) begin
            res_data = {sign_q, 11'h7FF, 52'd0};
         end else begin
            res_data          = {sign_q, FP64_QNAN[62:0]};
            res_flags.invalid = !mant_q[62];
         end
      end else if (e64_r >= E_MAX) begin
         res_data           = {sign_q, 11'h7FF, 52'd0};
         res_flags.overflow = 1'b1;
         res_flags.inexact  = 1'b1;
      end else if (e64_r <= 17'sd0) begin
         res_flags.underflow = 1'b1;
         res_flags.inexact   = 1'b1;
      end else begin
         res_data          = {sign_q, e64_r[10:0], frac_sum[51:0]};
         res_flags.inexact = g | r | st;
      end
   end

   //---------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         out_q   <= '0;
         flags_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign_q <= bus.in_data[79];
                  exp_q  <= {2'b00, bus.in_data[78:64]};
                  mant_q <= bus.in_data[63:0];
               end
            end
`ifdef FP80_CONV_UNNORM_EN
            NORM: begin
               if (mant_q[63:56] == 8'd0) begin
                  mant_q <= mant_q << 8;
                  exp_q  <= exp_q - 17'sd8;
               end else begin
                  mant_q <= mant_q << lz;
                  exp_q  <= exp_q - {14'd0, lz};
               end
            end
`endif
            ROUND: begin
               out_q   <= res_data;
               flags_q <= res_flags;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready      = (state == IDLE);
   assign bus.out_valid     = (state == DONE);
   assign bus.out_data      = out_q;
   assign bus.out_inexact   = flags_q.inexact;
   assign bus.out_overflow  = flags_q.overflow;
   assign bus.out_underflow = flags_q.underflow;
   assign bus.out_invalid   = flags_q.invalid;

endmodule

// File: tb/tb_fp80_to_fp64_conv.sv
// Directed testbench for fp80_to_fp64_conv. Expected results are hand-derived
// binary64 encodings; flags are packed {inexact, overflow, underflow, invalid}.
module tb_fp80_to_fp64_conv;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   fp80_to_fp64_conv_if bus ();

   fp80_to_fp64_conv dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Drives one operand and returns the first valid result, its flags and the
   // number of cycles from acceptance to out_valid. Completes the output
   // handshake only when out_ready is high.
   task automatic run_op(input logic [79:0] din, output logic [63:0] dout,
                         output logic [3:0] fl, output int lat);
      int w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      bus.in_data  = din;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      dout = bus.out_data;
      fl   = {bus.out_inexact, bus.out_overflow, bus.out_underflow, bus.out_invalid};
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      n_checks++;
      if (bus.out_data !== 64'd0) begin
         n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
      end
      n_checks++;
      if ({bus.out_inexact, bus.out_overflow, bus.out_underflow, bus.out_invalid} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000",
            {bus.out_inexact, bus.out_overflow, bus.out_underflow, bus.out_invalid});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_normal();
      logic [63:0] d; logic [3:0] fl; int lat;
      run_op(80'h3FFF_8000000000000000, d, fl, lat);
      n_checks++;
      if (d !== 64'h3FF0000000000000) begin
         n_fail++; $display("FAIL normal_data: got %h want 3ff0000000000000", d);
      end
      n_checks++;
      if (fl !== 4'b0000) begin
         n_fail++; $display("FAIL normal_flags: got %b want 0000", fl);
      end
      n_checks++;
      if (lat !== 2) begin
         n_fail++; $display("FAIL normal_latency: got %0d want 2", lat);
      end
   endtask

   task automatic test_round();
      logic [79:0] vin  [3] = '{80'h3FFF_8000000000000400, 80'h3FFF_8000000000000C00,
                               80'h3FFF_8000000000000401};
      logic [63:0] vout [3] = '{64'h3FF0000000000000, 64'h3FF0000000000002,
                               64'h3FF0000000000001};
      logic [63:0] d; logic [3:0] fl; int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(vin[i], d, fl, lat);
         n_checks++;
         if (d !== vout[i]) begin
            n_fail++; $display("FAIL round_data[%0d]: got %h want %h", i, d, vout[i]);
         end
         n_checks++;
         if (fl !== 4'b1000) begin
            n_fail++; $display("FAIL round_flags[%0d]: got %b want 1000", i, fl);
         end
      end
   endtask

   task automatic test_range();
      logic [79:0] vin  [5] = '{80'h43FF_8000000000000000, 80'hBC00_8000000000000000,
                               80'h0000_0000000000000000, 80'h7FFF_8000000000000000,
                               80'h0000_0000000000000001};
      logic [63:0] vout [5] = '{64'h7FF0000000000000, 64'h8000000000000000,
                               64'h0000000000000000, 64'h7FF0000000000000,
                               64'h0000000000000000};
      logic [3:0]  vfl  [5] = '{4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b1010};
      logic [63:0] d; logic [3:0] fl; int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(vin[i], d, fl, lat);
         n_checks++;
         if (d !== vout[i]) begin
            n_fail++; $display("FAIL range_data[%0d]: got %h want %h", i, d, vout[i]);
         end
         n_checks++;
         if (fl !== vfl[i]) begin
            n_fail++; $display("FAIL range_flags[%0d]: got %b want %b", i, fl, vfl[i]);
         end
      end
   endtask

   task automatic test_unnormal();
      logic [63:0] d; logic [3:0] fl; int lat;
      logic [63:0] want_d;
      logic [3:0]  want_fl;
      int          want_lat;
`ifdef FP80_CONV_UNNORM_EN
      want_d = 64'h3FF0000000000000; want_fl = 4'b0000; want_lat = 5;
`else
      want_d = 64'h0000000000000000; want_fl = 4'b1000; want_lat = 2;
`endif
      run_op(80'h4013_0000080000000000, d, fl, lat);
      n_checks++;
      if (d !== want_d) begin
         n_fail++; $display("FAIL unnormal_data: got %h want %h", d, want_d);
      end
      n_checks++;
      if (fl !== want_fl) begin
         n_fail++; $display("FAIL unnormal_flags: got %b want %b", fl, want_fl);
      end
      n_checks++;
      if (lat !== want_lat) begin
         n_fail++; $display("FAIL unnormal_latency: got %0d want %0d", lat, want_lat);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] d; logic [3:0] fl; int lat;
      bus.out_ready = 1'b0;
      run_op(80'h7FFF_A000000000000000, d, fl, lat);
      n_checks++;
      if (d !== 64'h7FF8000000000000 || fl !== 4'b0001) begin
         n_fail++; $display("FAIL snan_result: got %h/%b want 7ff8000000000000/0001", d, fl);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h7FF8000000000000 ||
             bus.out_invalid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold[%0d]: got v=%b d=%h inv=%b rdy=%b want v=1 d=7ff8000000000000 inv=1 rdy=0",
                     i, bus.out_valid, bus.out_data, bus.out_invalid, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_release: got rdy=%b v=%b want rdy=1 v=0",
                            bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] d; logic [3:0] fl; int lat;
      bus.in_data  = 80'h4013_0000080000000000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
`ifdef FP80_CONV_UNNORM_EN
      @(posedge clk);   // now in the second NORM cycle
      #1;
`endif
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midreset_handshake: got v=%b rdy=%b want v=0 rdy=1",
                            bus.out_valid, bus.in_ready);
      end
      n_checks++;
      if (bus.out_data !== 64'd0) begin
         n_fail++; $display("FAIL midreset_out_data: got %h want 0", bus.out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(80'hC000_8000000000000000, d, fl, lat);
      n_checks++;
      if (d !== 64'hC000000000000000 || fl !== 4'b0000 || lat !== 2) begin
         n_fail++; $display("FAIL midreset_next_op: got %h/%b/%0d want c000000000000000/0000/2",
                            d, fl, lat);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_round();
      test_range();
      test_unnormal();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
